fpu_op_sequencer: RTL and testbench

FPU_OP_SEQUENCER -- requirements
Module: fpu_op_sequencer

---
 rtl/fpu_pkg.sv | 22 ++
 rtl/fpu_op_fifo.sv | 55 +++++
 rtl/fpu_op_sequencer.sv | 105 ++++++++++
 tb/tb_fpu_op_sequencer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared FPU types and sequencer defaults
package fpu_pkg;

  typedef enum logic [3:0] {
    OVERFLOW  = 4'd0,
    UNDERFLOW = 4'd1,
    EXACT     = 4'd2,
    INEXACT   = 4'd3
  } status_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_HOLD    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_PRESENT = 3'd4
  } seq_state_t;

  localparam int DEFAULT_DEPTH       = 4;
  localparam int DEFAULT_HOLD_CYCLES = 64;

endpackage

// File: rtl/fpu_op_fifo.sv
// rtl/fpu_op_fifo.sv - operand-pair FIFO with power-of-two depth
module fpu_op_fifo
  import fpu_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_pop_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  // Guarded here so a push while full can never overwrite the head entry.
  assign w_push     = i_push && !o_full;
  assign w_pop      = i_pop && !o_empty;
  assign o_full     = (r_count == CW'(DEPTH));
  assign o_empty    = (r_count == '0);
  assign o_pop_data = r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_data;
  end

endmodule

// File: rtl/fpu_op_sequencer.sv
// rtl/fpu_op_sequencer.sv - queues operand pairs and paces them through a slow FPU
module fpu_op_sequencer
  import fpu_pkg::*;
#(
  parameter int DEPTH       = DEFAULT_DEPTH,
  parameter int HOLD_CYCLES = DEFAULT_HOLD_CYCLES
) (
  input  logic        clock_100Khz,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_op_a,
  input  logic [31:0] in_op_b,
  output logic [31:0] fpu_op_a,
  output logic [31:0] fpu_op_b,
  input  logic [31:0] fpu_data,
  input  status_t     fpu_status,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output status_t     res_status,
  output logic        busy
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  seq_state_t    r_state;
  logic [HW-1:0] r_hold_cnt;
  logic [31:0]   r_fpu_op_a;
  logic [31:0]   r_fpu_op_b;
  logic [31:0]   r_res_data;
  status_t       r_res_status;
  logic          r_res_valid;
  logic [63:0]   w_head;
  logic          w_full;
  logic          w_empty;
  logic          w_pop;

  assign w_pop = (r_state == ST_LOAD);

  fpu_op_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (64)
  ) u_fifo (
    .clk         (clock_100Khz),
    .rst_n       (reset),
    .i_push      (in_valid),
    .i_push_data ({in_op_a, in_op_b}),
    .i_pop       (w_pop),
    .o_pop_data  (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  always_ff @(posedge clock_100Khz or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_hold_cnt   <= '0;
      r_fpu_op_a   <= '0;
      r_fpu_op_b   <= '0;
      r_res_data   <= '0;
      r_res_status <= EXACT;
      r_res_valid  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) r_state <= ST_LOAD;
        end
        ST_LOAD: begin
          {r_fpu_op_a, r_fpu_op_b} <= w_head;
          r_hold_cnt               <= '0;
          r_state                  <= ST_HOLD;
        end
        ST_HOLD: begin
          // Counter stops at its last value so it never wraps within one pass.
          if (r_hold_cnt == HOLD_LAST) r_state <= ST_CAPTURE;
          else                         r_hold_cnt <= r_hold_cnt + HW'(1);
        end
        ST_CAPTURE: begin
          r_res_data   <= fpu_data;
          r_res_status <= fpu_status;
          r_res_valid  <= 1'b1;
          r_state      <= ST_PRESENT;
        end
        ST_PRESENT: begin
          if (r_res_valid && res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready   = !w_full;
  assign fpu_op_a   = r_fpu_op_a;
  assign fpu_op_b   = r_fpu_op_b;
  assign res_valid  = r_res_valid;
  assign res_data   = r_res_data;
  assign res_status = r_res_status;
  assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// tb/tb_fpu_op_sequencer.sv - directed self-checking bench for fpu_op_sequencer
`timescale 1ns/1ps
module tb_fpu_op_sequencer;
  import fpu_pkg::*;

  logic        clock_100Khz = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_op_a;
  logic [31:0] in_op_b;
  logic [31:0] fpu_op_a;
  logic [31:0] fpu_op_b;
  logic [31:0] fpu_data;
  status_t     fpu_status;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  status_t     res_status;
  logic        busy;

  logic        stub_sum;
  logic [31:0] stub_data;
  status_t     stub_status;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock_100Khz = ~clock_100Khz;

  // FPU stub: a fixed value, or op_a + op_b so every result identifies its pair.
  assign fpu_data   = stub_sum ? (fpu_op_a + fpu_op_b) : stub_data;
  assign fpu_status = stub_status;

  fpu_op_sequencer dut (
    .clock_100Khz (clock_100Khz),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_op_a      (in_op_a),
    .in_op_b      (in_op_b),
    .fpu_op_a     (fpu_op_a),
    .fpu_op_b     (fpu_op_b),
    .fpu_data     (fpu_data),
    .fpu_status   (fpu_status),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_data     (res_data),
    .res_status   (res_status),
    .busy         (busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push_pair(input logic [31:0] a, input logic [31:0] b);
    int t;
    in_valid = 1'b1;
    in_op_a  = a;
    in_op_b  = b;
    t = 0;
    while (!in_ready && t < 1000) begin
      @(negedge clock_100Khz);
      t++;
    end
    if (t >= 1000) check("push_timeout", 64'(t < 1000), 64'd1);
    @(negedge clock_100Khz);
    in_valid = 1'b0;
  endtask

  task automatic collect(input string tag, input logic [31:0] exp_data, input status_t exp_status,
                         input logic [31:0] exp_a, input logic [31:0] exp_b);
    int t;
    t = 0;
    while (!res_valid && t < 1000) begin
      @(negedge clock_100Khz);
      t++;
    end
    check({tag, "_wait"}, 64'(t < 1000), 64'd1);
    check({tag, "_data"}, 64'(res_data), 64'(exp_data));
    check({tag, "_status"}, 64'(res_status), 64'(exp_status));
    check({tag, "_op_a"}, 64'(fpu_op_a), 64'(exp_a));
    check({tag, "_op_b"}, 64'(fpu_op_b), 64'(exp_b));
    @(negedge clock_100Khz);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] qa [5];
    logic [31:0] qb [5];
    logic [31:0] wa [10];
    logic [31:0] wb [10];
    int          n;
    logic        bad;

    reset = 1'b0; in_valid = 1'b0; res_ready = 1'b0;
    in_op_a = '0; in_op_b = '0;
    stub_sum = 1'b0; stub_data = 32'h4030_0000; stub_status = EXACT;

    repeat (3) @(negedge clock_100Khz);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_op_a", 64'(fpu_op_a), 64'd0);
    check("rst_op_b", 64'(fpu_op_b), 64'd0);
    check("rst_res_data", 64'(res_data), 64'd0);
    check("rst_res_status", 64'(res_status), 64'(EXACT));
    reset = 1'b1;
    repeat (2) @(negedge clock_100Khz);

    // Single pair: latency and operand stability
    push_pair(32'h4020_0000, 32'h4000_0000);
    n = 0; bad = 1'b0;
    while (!res_valid && n < 200) begin
      @(negedge clock_100Khz);
      n++;
      if (n >= 2 && (fpu_op_a !== 32'h4020_0000 || fpu_op_b !== 32'h4000_0000)) bad = 1'b1;
    end
    check("single_latency", 64'(n), 64'd67);
    check("single_ops_stable", 64'(bad), 64'd0);
    check("single_data", 64'(res_data), 64'h4030_0000);
    check("single_status", 64'(res_status), 64'(EXACT));

    // Fill while result 1 is unconsumed: no pops, so the 5th pair must stall
    for (int i = 0; i < 5; i++) begin
      qa[i] = 32'h3F80_0000 + 32'(i);
      qb[i] = 32'h0100_0000 * 32'(i + 1);
    end
    for (int i = 0; i < 4; i++) push_pair(qa[i], qb[i]);
    check("fill_in_ready_low", 64'(in_ready), 64'd0);
    check("fill_busy", 64'(busy), 64'd1);
    in_valid = 1'b1; in_op_a = qa[4]; in_op_b = qb[4];
    bad = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock_100Khz);
      if (!res_valid || res_data !== 32'h4030_0000 || res_status !== EXACT || in_ready ||
          !busy || fpu_op_a !== 32'h4020_0000) bad = 1'b1;
    end
    check("backpressure_stable", 64'(bad), 64'd0);

    stub_sum = 1'b1; res_ready = 1'b1;
    fork
      push_pair(qa[4], qb[4]);
      begin
        collect("drain0", 32'h4030_0000, EXACT, 32'h4020_0000, 32'h4000_0000);
        for (int i = 0; i < 5; i++)
          collect($sformatf("drain%0d", i + 1), qa[i] + qb[i], EXACT, qa[i], qb[i]);
      end
    join

    // Wrap: ten pairs streamed with res_ready held high
    for (int i = 0; i < 10; i++) begin
      wa[i] = 32'h1000_0000 + 32'(i * 32'h111);
      wb[i] = 32'h0002_0000 * 32'(i + 3);
    end
    fork
      for (int i = 0; i < 10; i++) push_pair(wa[i], wb[i]);
      for (int j = 0; j < 10; j++)
        collect($sformatf("wrap%0d", j), wa[j] + wb[j], EXACT, wa[j], wb[j]);
    join

    // Status pass-through
    stub_sum = 1'b0; stub_data = 32'h7F80_0000; stub_status = OVERFLOW;
    push_pair(32'h7F00_0000, 32'h7F00_0000);
    collect("stat_ovf", 32'h7F80_0000, OVERFLOW, 32'h7F00_0000, 32'h7F00_0000);
    stub_data = 32'h3EAA_AAAB; stub_status = INEXACT;
    push_pair(32'h3F80_0000, 32'h4040_0000);
    collect("stat_inexact", 32'h3EAA_AAAB, INEXACT, 32'h3F80_0000, 32'h4040_0000);

    // Reset mid-HOLD with two pairs queued
    res_ready = 1'b0; stub_data = 32'h1234_5678; stub_status = UNDERFLOW;
    push_pair(32'hAAAA_0001, 32'hBBBB_0001);
    push_pair(32'hAAAA_0002, 32'hBBBB_0002);
    push_pair(32'hAAAA_0003, 32'hBBBB_0003);
    repeat (30) @(negedge clock_100Khz);
    check("midhold_busy", 64'(busy), 64'd1);
    check("midhold_op_a", 64'(fpu_op_a), 64'hAAAA_0001);
    reset = 1'b0;
    #1;
    check("async_busy", 64'(busy), 64'd0);
    check("async_op_a", 64'(fpu_op_a), 64'd0);
    check("async_op_b", 64'(fpu_op_b), 64'd0);
    check("async_res_valid", 64'(res_valid), 64'd0);
    check("async_res_data", 64'(res_data), 64'd0);
    check("async_res_status", 64'(res_status), 64'(EXACT));
    check("async_in_ready", 64'(in_ready), 64'd1);
    repeat (2) @(negedge clock_100Khz);
    reset = 1'b1;
    res_ready = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clock_100Khz);
      if (res_valid || busy || !in_ready) bad = 1'b1;
    end
    check("post_reset_quiet", 64'(bad), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
